// File: rtl/cp0_pkg.sv
// Shared CP0 definitions: register addresses ({rd, sel}), exception codes and
// Status/Cause field bit positions.
package cp0_pkg;

  localparam logic [7:0] CR_BADVADDR = 8'h40;
  localparam logic [7:0] CR_COUNT    = 8'h48;
  localparam logic [7:0] CR_COMPARE  = 8'h58;
  localparam logic [7:0] CR_STATUS   = 8'h60;
  localparam logic [7:0] CR_CAUSE    = 8'h68;
  localparam logic [7:0] CR_EPC      = 8'h70;

  localparam logic [4:0] EXC_INT  = 5'h00;
  localparam logic [4:0] EXC_ADEL = 5'h04;
  localparam logic [4:0] EXC_ADES = 5'h05;
  localparam logic [4:0] EXC_SYS  = 5'h08;
  localparam logic [4:0] EXC_BP   = 5'h09;
  localparam logic [4:0] EXC_RI   = 5'h0a;
  localparam logic [4:0] EXC_OV   = 5'h0c;

  localparam int ST_IE    = 0;
  localparam int ST_EXL   = 1;
  localparam int ST_IM_LO = 8;
  localparam int ST_BEV   = 22;

  localparam int CA_EXC_LO = 2;
  localparam int CA_IP_LO  = 8;
  localparam int CA_TI     = 30;
  localparam int CA_BD     = 31;

endpackage

// File: rtl/cp0_int_sync.sv
// N-line flip-flop synchroniser, STAGES deep (0 = combinational bypass),
// synchronous active-high reset to 0.
module cp0_int_sync #(
  parameter int N      = 6,
  parameter int STAGES = 2
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [N-1:0] d,
  output logic [N-1:0] q
);

  generate
    if (STAGES == 0) begin : g_bypass
      logic unused_clk_reset;
      assign unused_clk_reset = clk ^ reset;
      assign q = d;
    end else begin : g_sync
      logic [N-1:0] sr [STAGES];
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int i = 0; i < STAGES; i++) sr[i] <= '0;
        end else begin
          sr[0] <= d;
          for (int i = 1; i < STAGES; i++) sr[i] <= sr[i-1];
        end
      end
      assign q = sr[STAGES-1];
    end
  endgenerate

endmodule

// File: rtl/cp0_unit.sv
// CP0 coprocessor: BadVAddr, Count, Compare, Status, Cause, EPC and interrupt request.
// Timer (Count/Compare/prescaler/TI) is present only when CP0_TIMER_EN is defined.
module cp0_unit
  import cp0_pkg::*;
#(
  parameter int EXT_INT_W   = 6,
  parameter int SYNC_STAGES = 2,
  parameter int TICK_DIV    = 2
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           cp0_addr,
  input  logic [31:0]          cp0_wdata,
  input  logic                 mtc0_we,
  input  logic [EXT_INT_W-1:0] ext_int_in,
  input  logic                 ex_ex,
  input  logic                 ex_bd,
  input  logic [31:0]          ex_pc,
  input  logic [4:0]           ex_excode,
  input  logic [31:0]          ex_badvaddr,
  input  logic                 eret_flush,
  output logic [31:0]          cp0_rdata,
  output logic [31:0]          epc,
  output logic                 has_int
);

  generate
    if (EXT_INT_W < 1 || EXT_INT_W > 6 || TICK_DIV < 1 || SYNC_STAGES < 0) begin : g_bad_cfg
      $error("cp0_unit: unsupported parameter set");
    end
  endgenerate

  logic wr_status, wr_cause, wr_epc;
  assign wr_status = mtc0_we && (cp0_addr == CR_STATUS);
  assign wr_cause  = mtc0_we && (cp0_addr == CR_CAUSE);
  assign wr_epc    = mtc0_we && (cp0_addr == CR_EPC);

  logic [EXT_INT_W-1:0] ext_sync;
  logic [5:0]           ip_hw;
  logic [1:0]           ip_sw;
  logic [7:0]           ip, im;
  logic                 ie, exl, bd, ti;
  logic [4:0]           exccode;
  logic [31:0]          badvaddr, count_val, compare_val;

  cp0_int_sync #(.N(EXT_INT_W), .STAGES(SYNC_STAGES)) u_int_sync (
    .clk   (clk),
    .reset (reset),
    .d     (ext_int_in),
    .q     (ext_sync)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      ip_hw    <= '0;
      ip_sw    <= '0;
      im       <= '0;
      ie       <= 1'b0;
      exl      <= 1'b0;
      bd       <= 1'b0;
      exccode  <= '0;
      epc      <= '0;
      badvaddr <= '0;
    end else begin
      ip_hw <= 6'(ext_sync);
      if (wr_cause) ip_sw <= cp0_wdata[CA_IP_LO+1:CA_IP_LO];
      if (wr_status) begin
        im <= cp0_wdata[ST_IM_LO+7:ST_IM_LO];
        ie <= cp0_wdata[ST_IE];
      end
      if (ex_ex)           exl <= 1'b1;
      else if (eret_flush) exl <= 1'b0;
      else if (wr_status)  exl <= cp0_wdata[ST_EXL];
      // A nested exception (EXL already set) keeps the original return point.
      if (ex_ex && !exl) begin
        bd  <= ex_bd;
        epc <= ex_bd ? ex_pc - 32'd4 : ex_pc;
      end else if (wr_epc) begin
        epc <= cp0_wdata;
      end
      if (ex_ex) exccode <= ex_excode;
      if (ex_ex && (ex_excode == EXC_ADEL || ex_excode == EXC_ADES)) badvaddr <= ex_badvaddr;
    end
  end

`ifdef CP0_TIMER_EN
  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  logic [PW-1:0] pre;
  logic          wr_count, wr_compare;
  assign wr_count   = mtc0_we && (cp0_addr == CR_COUNT);
  assign wr_compare = mtc0_we && (cp0_addr == CR_COMPARE);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre         <= '0;
      count_val   <= '0;
      compare_val <= '0;
      ti          <= 1'b0;
    end else begin
      if (wr_count) begin
        count_val <= cp0_wdata;
        pre       <= '0;
      end else if (pre == PW'(TICK_DIV - 1)) begin
        pre       <= '0;
        count_val <= count_val + 32'd1;
      end else begin
        pre <= pre + 1'b1;
      end
      if (wr_compare) begin
        compare_val <= cp0_wdata;
        ti          <= 1'b0;
      end else if (count_val == compare_val) begin
        ti <= 1'b1;
      end
    end
  end
`else
  assign count_val   = '0;
  assign compare_val = '0;
  assign ti          = 1'b0;
`endif

  assign ip      = {ip_hw[5] | ti, ip_hw[4:0], ip_sw};
  assign has_int = (|(ip & im)) & ie & ~exl;

  always_comb begin
    cp0_rdata = '0;
    case (cp0_addr)
      CR_BADVADDR: cp0_rdata = badvaddr;
      CR_COUNT:    cp0_rdata = count_val;
      CR_COMPARE:  cp0_rdata = compare_val;
      CR_STATUS: begin
        cp0_rdata[ST_BEV]             = 1'b1;
        cp0_rdata[ST_IM_LO+7:ST_IM_LO] = im;
        cp0_rdata[ST_EXL]             = exl;
        cp0_rdata[ST_IE]              = ie;
      end
      CR_CAUSE: begin
        cp0_rdata[CA_BD]                 = bd;
        cp0_rdata[CA_TI]                 = ti;
        cp0_rdata[CA_IP_LO+7:CA_IP_LO]   = ip;
        cp0_rdata[CA_EXC_LO+4:CA_EXC_LO] = exccode;
      end
      CR_EPC:      cp0_rdata = epc;
      default:     cp0_rdata = '0;
    endcase
  end

endmodule

// File: tb/tb_cp0_unit.sv
// Directed bench for cp0_unit; adapts its timer checks to whether CP0_TIMER_EN is defined.
module tb_cp0_unit;
  localparam int SYNC = 2;

  localparam logic [7:0] A_BVA = 8'h40, A_CNT = 8'h48, A_CMP = 8'h58,
                         A_ST  = 8'h60, A_CA  = 8'h68, A_EPC = 8'h70;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  cp0_addr = 8'h00;
  logic [31:0] cp0_wdata = '0;
  logic        mtc0_we = 1'b0;
  logic [5:0]  ext_int_in = '0;
  logic        ex_ex = 1'b0, ex_bd = 1'b0, eret_flush = 1'b0;
  logic [31:0] ex_pc = '0, ex_badvaddr = '0;
  logic [4:0]  ex_excode = '0;
  logic [31:0] cp0_rdata, epc;
  logic        has_int;

  int vec = 0;
  int miss = 0;
  logic [31:0] d;

  cp0_unit #(.EXT_INT_W(6), .SYNC_STAGES(SYNC), .TICK_DIV(2)) dut (
    .clk(clk), .reset(reset), .cp0_addr(cp0_addr), .cp0_wdata(cp0_wdata),
    .mtc0_we(mtc0_we), .ext_int_in(ext_int_in), .ex_ex(ex_ex), .ex_bd(ex_bd),
    .ex_pc(ex_pc), .ex_excode(ex_excode), .ex_badvaddr(ex_badvaddr),
    .eret_flush(eret_flush), .cp0_rdata(cp0_rdata), .epc(epc), .has_int(has_int)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] v);
    cp0_addr = a;
    #1;
    v = cp0_rdata;
  endtask

  task automatic mtc0(input logic [7:0] a, input logic [31:0] v);
    cp0_addr = a; cp0_wdata = v; mtc0_we = 1'b1;
    tick();
    mtc0_we = 1'b0;
  endtask

  task automatic exc(input logic bdv, input logic [31:0] pc, input logic [4:0] code,
                     input logic [31:0] bva);
    ex_ex = 1'b1; ex_bd = bdv; ex_pc = pc; ex_excode = code; ex_badvaddr = bva;
    tick();
    ex_ex = 1'b0; ex_bd = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    rd(A_ST, d);  vec++; if (d !== 32'h00400000) begin miss++; $display("FAIL reset_status got %h want %h", d, 32'h00400000); end
    rd(A_CA, d);  vec++; if (d !== 32'h0) begin miss++; $display("FAIL reset_cause got %h want 0", d); end
    rd(A_EPC, d); vec++; if (d !== 32'h0) begin miss++; $display("FAIL reset_epc got %h want 0", d); end
    rd(A_BVA, d); vec++; if (d !== 32'h0) begin miss++; $display("FAIL reset_badvaddr got %h want 0", d); end
    rd(A_CNT, d); vec++; if (d !== 32'h0) begin miss++; $display("FAIL reset_count got %h want 0", d); end
    rd(A_CMP, d); vec++; if (d !== 32'h0) begin miss++; $display("FAIL reset_compare got %h want 0", d); end
    vec++; if (has_int !== 1'b0 || epc !== 32'h0) begin miss++; $display("FAIL reset_outputs got has_int=%b epc=%h want 0/0", has_int, epc); end
    reset = 1'b0;
    tick();
    rd(8'h08, d); vec++; if (d !== 32'h0) begin miss++; $display("FAIL unmapped_read got %h want 0", d); end
  endtask

`ifdef CP0_TIMER_EN
  task automatic test_timer();
    mtc0(A_ST, 32'h00008001);
    mtc0(A_CMP, 32'd20);
    mtc0(A_CNT, 32'd10);
    repeat (20) tick();
    rd(A_CNT, d); vec++; if (d !== 32'd20) begin miss++; $display("FAIL timer_count20 got %0d want 20", d); end
    rd(A_CA, d);  vec++; if (d[30] !== 1'b0 || has_int !== 1'b0) begin miss++; $display("FAIL timer_ti_early got ti=%b has_int=%b want 0/0", d[30], has_int); end
    tick();
    rd(A_CA, d);  vec++; if ((d & 32'h40008000) !== 32'h40008000 || has_int !== 1'b1) begin miss++; $display("FAIL timer_ti_set got cause=%h has_int=%b want ti/ip7 set, 1", d, has_int); end
    mtc0(A_CMP, 32'd100);
    rd(A_CA, d);  vec++; if (d[30] !== 1'b0 || has_int !== 1'b0) begin miss++; $display("FAIL timer_ti_clear got ti=%b has_int=%b want 0/0", d[30], has_int); end
    mtc0(A_CMP, 32'hFFFF0000);
  endtask

  task automatic test_count_wrap();
    mtc0(A_CNT, 32'd5);
    tick();
    mtc0(A_CNT, 32'hFFFFFFFF);
    rd(A_CNT, d); vec++; if (d !== 32'hFFFFFFFF) begin miss++; $display("FAIL wrap_write_wins got %h want ffffffff", d); end
    tick();
    rd(A_CNT, d); vec++; if (d !== 32'hFFFFFFFF) begin miss++; $display("FAIL wrap_prescale got %h want ffffffff", d); end
    tick();
    rd(A_CNT, d); vec++; if (d !== 32'h0) begin miss++; $display("FAIL wrap_zero got %h want 0", d); end
  endtask
`else
  task automatic test_no_timer();
    mtc0(A_CNT, 32'd123);
    mtc0(A_CMP, 32'd5);
    rd(A_CNT, d); vec++; if (d !== 32'h0) begin miss++; $display("FAIL notimer_count got %h want 0", d); end
    rd(A_CMP, d); vec++; if (d !== 32'h0) begin miss++; $display("FAIL notimer_compare got %h want 0", d); end
    for (int i = 0; i < 6; i++) begin
      tick();
      rd(A_CA, d); vec++; if (d[30] !== 1'b0) begin miss++; $display("FAIL notimer_ti cycle %0d got %b want 0", i, d[30]); end
    end
  endtask
`endif

  task automatic test_exceptions();
    mtc0(A_ST, 32'h00008001);
    exc(1'b1, 32'hBFC00104, 5'h04, 32'h00001003);
    vec++; if (epc !== 32'hBFC00100) begin miss++; $display("FAIL exc_epc got %h want bfc00100", epc); end
    rd(A_CA, d);  vec++; if ((d & 32'h8000007C) !== 32'h80000010) begin miss++; $display("FAIL exc_cause got %h want bd=1 code=4", d); end
    rd(A_BVA, d); vec++; if (d !== 32'h00001003) begin miss++; $display("FAIL exc_badvaddr got %h want 00001003", d); end
    rd(A_ST, d);  vec++; if (d !== 32'h00408003 || has_int !== 1'b0) begin miss++; $display("FAIL exc_status got %h has_int=%b want 00408003/0", d, has_int); end
    exc(1'b0, 32'h00000200, 5'h0c, 32'h0000DEAD);
    rd(A_EPC, d); vec++; if (d !== 32'hBFC00100) begin miss++; $display("FAIL nested_epc got %h want bfc00100", d); end
    rd(A_CA, d);  vec++; if ((d & 32'h8000007C) !== 32'h80000030) begin miss++; $display("FAIL nested_cause got %h want bd=1 code=0c", d); end
    rd(A_BVA, d); vec++; if (d !== 32'h00001003) begin miss++; $display("FAIL nested_badvaddr got %h want 00001003", d); end
    eret_flush = 1'b1; tick(); eret_flush = 1'b0;
    rd(A_ST, d);  vec++; if (d !== 32'h00408001) begin miss++; $display("FAIL eret_status got %h want 00408001", d); end
  endtask

  task automatic test_back_to_back();
    ex_ex = 1'b1; ex_bd = 1'b0; ex_pc = 32'h00000300; ex_excode = 5'h08; eret_flush = 1'b1;
    tick();
    ex_ex = 1'b0; eret_flush = 1'b0;
    rd(A_ST, d);  vec++; if (d[1] !== 1'b1) begin miss++; $display("FAIL ex_vs_eret exl got %b want 1", d[1]); end
    rd(A_CA, d);  vec++; if ((d & 32'h8000007C) !== 32'h00000020) begin miss++; $display("FAIL ex_vs_eret cause got %h want bd=0 code=08", d); end
    eret_flush = 1'b1; tick(); eret_flush = 1'b0;
    cp0_addr = A_EPC; cp0_wdata = 32'h00001234; mtc0_we = 1'b1;
    ex_ex = 1'b1; ex_pc = 32'h00000400; ex_excode = 5'h0a;
    tick();
    mtc0_we = 1'b0; ex_ex = 1'b0;
    vec++; if (epc !== 32'h00000400) begin miss++; $display("FAIL epc_ex_over_mtc0 got %h want 00000400", epc); end
    eret_flush = 1'b1; tick(); eret_flush = 1'b0;
    mtc0(A_EPC, 32'h00001234);
    vec++; if (epc !== 32'h00001234) begin miss++; $display("FAIL epc_mtc0 got %h want 00001234", epc); end
  endtask

  task automatic test_ext_int();
    mtc0(A_ST, 32'h00000401);
    ext_int_in[0] = 1'b1;
    for (int k = 0; k < SYNC; k++) begin
      tick();
      vec++; if (has_int !== 1'b0) begin miss++; $display("FAIL ext_rise_early edge %0d got %b want 0", k + 1, has_int); end
    end
    tick();
    vec++; if (has_int !== 1'b1) begin miss++; $display("FAIL ext_rise got %b want 1", has_int); end
    rd(A_CA, d); vec++; if (d[10] !== 1'b1) begin miss++; $display("FAIL ext_ip2 got %b want 1", d[10]); end
    ext_int_in[0] = 1'b0;
    repeat (SYNC) tick();
    vec++; if (has_int !== 1'b1) begin miss++; $display("FAIL ext_fall_early got %b want 1", has_int); end
    tick();
    vec++; if (has_int !== 1'b0) begin miss++; $display("FAIL ext_fall got %b want 0", has_int); end
    mtc0(A_ST, 32'h00008001);
    ext_int_in[5] = 1'b1;
    repeat (SYNC + 1) tick();
    rd(A_CA, d); vec++; if (d[15] !== 1'b1 || has_int !== 1'b1) begin miss++; $display("FAIL ext5_ip7 got ip7=%b has_int=%b want 1/1", d[15], has_int); end
    ext_int_in[5] = 1'b0;
    repeat (SYNC + 1) tick();
    mtc0(A_CA, 32'h00000100);
    mtc0(A_ST, 32'h00000101);
    rd(A_CA, d); vec++; if ((d & 32'h0000FF00) !== 32'h00000100 || has_int !== 1'b1) begin miss++; $display("FAIL sw_int got cause=%h has_int=%b want ip=01, 1", d, has_int); end
    mtc0(A_CA, 32'h00000000);
    vec++; if (has_int !== 1'b0) begin miss++; $display("FAIL sw_int_clear got %b want 0", has_int); end
  endtask

  task automatic test_mid_reset();
    mtc0(A_ST, 32'h0000FF01);
    exc(1'b0, 32'h00000500, 5'h05, 32'h00000777);
    ext_int_in = 6'h3F;
    tick();
    reset = 1'b1;
    tick();
    ext_int_in = '0;
    rd(A_ST, d);  vec++; if (d !== 32'h00400000) begin miss++; $display("FAIL midreset_status got %h want 00400000", d); end
    rd(A_CA, d);  vec++; if (d !== 32'h0) begin miss++; $display("FAIL midreset_cause got %h want 0", d); end
    rd(A_BVA, d); vec++; if (d !== 32'h0 || epc !== 32'h0) begin miss++; $display("FAIL midreset_bva_epc got %h/%h want 0/0", d, epc); end
    rd(A_CNT, d); vec++; if (d !== 32'h0) begin miss++; $display("FAIL midreset_count got %h want 0", d); end
    reset = 1'b0;
    mtc0(A_ST, 32'h0000FC01);
    tick();
    vec++; if (has_int !== 1'b0) begin miss++; $display("FAIL midreset_sync_flushed got %b want 0", has_int); end
  endtask

  initial begin
    test_reset();
`ifdef CP0_TIMER_EN
    test_timer();
`else
    test_no_timer();
`endif
    test_exceptions();
    test_back_to_back();
    test_ext_int();
`ifdef CP0_TIMER_EN
    test_count_wrap();
`endif
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vec, miss);
    $finish;
  end

endmodule
